// File: rtl/sort_pkg.sv
// sort_pkg: elaboration-time helpers shared by the bitonic sorting pipeline.
//   clog2          - ceiling log2 of a positive integer
//   bitonic_stages - number of compare-exchange steps for a NUM-key network
//   stage_phase    - merge phase p (block size 2**p) that step s belongs to
//   stage_dist     - log2 of the partner distance used by step s
//   pair_lo        - lower lane index of compare pair m at a given distance
//   pair_desc      - native (pre-desc-flip) direction of a pair in a phase
package sort_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int bitonic_stages(input int num);
    int lg;
    lg = clog2(num);
    return lg * (lg + 1) / 2;
  endfunction

  // Steps are numbered in network order: phase p = 1..lg, and within each
  // phase the distance exponent runs from p-1 down to 0.
  function automatic int stage_phase(input int num, input int s);
    int r;
    int cnt;
    r = 0;
    cnt = 0;
    for (int p = 1; p <= clog2(num); p++) begin
      for (int q = p - 1; q >= 0; q--) begin
        if (cnt == s) r = p;
        cnt++;
      end
    end
    return r;
  endfunction

  function automatic int stage_dist(input int num, input int s);
    int r;
    int cnt;
    r = 0;
    cnt = 0;
    for (int p = 1; p <= clog2(num); p++) begin
      for (int q = p - 1; q >= 0; q--) begin
        if (cnt == s) r = q;
        cnt++;
      end
    end
    return r;
  endfunction

  // Insert a zero at bit position db of m: enumerates the lanes whose
  // partner (lane | 2**db) is above them, giving NUM/2 disjoint pairs.
  function automatic int pair_lo(input int m, input int db);
    return ((m >> db) << (db + 1)) | (m & ((1 << db) - 1));
  endfunction

  // Blocks of size 2**phase alternate ascending/descending; in the last
  // phase every lane index is below the block size, so all pairs ascend.
  function automatic bit pair_desc(input int lo, input int phase);
    return bit'((lo >> phase) & 1);
  endfunction

endpackage

// File: rtl/sort_cas.sv
// sort_cas: one combinational compare-and-swap cell.
//   a, b   - keys on the lower and upper lane of the pair
//   dir    - 0: lo receives the smaller key, 1: lo receives the larger key
//   lo, hi - keys routed back to the lower and upper lane
// Equal keys are never exchanged.
module sort_cas #(
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             dir,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic aGtB;
  logic aLtB;
  logic swap;

  if (SIGNED != 0) begin : g_signed
    assign aGtB = $signed(a) > $signed(b);
    assign aLtB = $signed(a) < $signed(b);
  end else begin : g_unsigned
    assign aGtB = a > b;
    assign aLtB = a < b;
  end

  assign swap = dir ? aLtB : aGtB;
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/sort_pipe.sv
// sort_pipe: pipelined bitonic sorter, one register rank per compare step.
//   clock, reset         - sole clock, asynchronous active-high reset
//   in_valid/in_ready    - input handshake; in_ready ignores in_valid
//   in_desc, in_data     - per-vector order select, NUM keys of WIDTH bits
//   out_valid/out_ready  - output handshake, driven straight from last rank
//   out_desc, out_data   - carried order bit and sorted keys (lane 0 first)
//   occupancy            - vectors currently held in the pipeline
module sort_pipe
  import sort_pkg::*;
#(
  parameter int NUM    = 4,
  parameter int WIDTH  = 16,
  parameter int SIGNED = 0
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     in_desc,
  input  logic [NUM*WIDTH-1:0]                     in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     out_desc,
  output logic [NUM*WIDTH-1:0]                     out_data,
  output logic [clog2(bitonic_stages(NUM)+1)-1:0]  occupancy
);

  localparam int STAGES = bitonic_stages(NUM);
  localparam int OCCW   = clog2(STAGES + 1);

  logic [STAGES:1]                     valid_q;
  logic [STAGES:1]                     desc_q;
  logic [STAGES:1][NUM-1:0][WIDTH-1:0] data_q;
  logic [OCCW-1:0]                     occ_q;
  logic [OCCW-1:0]                     occ_d;

  logic [STAGES-1:0][NUM-1:0][WIDTH-1:0] stageIn;
  logic [STAGES-1:0][NUM-1:0][WIDTH-1:0] stageOut_d;
  logic [STAGES-1:0]                     stageValid;
  logic [STAGES-1:0]                     stageDesc;
  logic [STAGES:1]                       en;
  logic                                  advance;
  logic                                  accept;
  logic                                  transfer;

  // Step s reads rank s (rank 0 is the input port) and feeds rank s+1.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int PH = stage_phase(NUM, s);
    localparam int DB = stage_dist(NUM, s);

    if (s == 0) begin : g_head
      assign stageIn[s]    = in_data;
      assign stageValid[s] = in_valid;
      assign stageDesc[s]  = in_desc;
    end else begin : g_body
      assign stageIn[s]    = data_q[s];
      assign stageValid[s] = valid_q[s];
      assign stageDesc[s]  = desc_q[s];
    end

    for (genvar m = 0; m < NUM / 2; m++) begin : g_cell
      localparam int LO = pair_lo(m, DB);
      localparam int HI = LO + (1 << DB);
      localparam bit PD = pair_desc(LO, PH);

      // Flipping every pair's direction mirrors the whole network,
      // which turns the ascending sort into a descending one.
      sort_cas #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
      ) u_cas (
        .a   (stageIn[s][LO]),
        .b   (stageIn[s][HI]),
        .dir (PD ^ stageDesc[s]),
        .lo  (stageOut_d[s][LO]),
        .hi  (stageOut_d[s][HI])
      );
    end
  end

  // A rank may load when it is empty or its successor is loading, so
  // bubbles collapse even while the output is stalled.
  always_comb begin
    en          = '0;
    advance     = out_ready | ~valid_q[STAGES];
    en[STAGES]  = advance;
    for (int k = STAGES - 1; k >= 1; k--) begin
      en[k] = ~valid_q[k] | en[k+1];
    end
  end

  assign in_ready = en[1];
  assign accept   = in_valid & en[1];
  assign transfer = valid_q[STAGES] & out_ready;

  always_comb begin
    occ_d = occ_q;
    if (accept && !transfer) begin
      occ_d = occ_q + OCCW'(1);
    end else if (!accept && transfer) begin
      occ_d = occ_q - OCCW'(1);
    end
  end

  // Payload is only captured alongside a valid bit, so a bubble never
  // pulls undriven input data into the pipe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      desc_q  <= '0;
      data_q  <= '0;
      occ_q   <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (en[k]) begin
          valid_q[k] <= stageValid[k-1];
          if (stageValid[k-1]) begin
            desc_q[k] <= stageDesc[k-1];
            data_q[k] <= stageOut_d[k-1];
          end
        end
      end
      occ_q <= occ_d;
    end
  end

  assign out_valid = valid_q[STAGES];
  assign out_desc  = desc_q[STAGES];
  assign out_data  = data_q[STAGES];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_sort_pipe.sv
// tb_sort_pipe: directed and randomized checks of sort_pipe against a
// queue-based reference that sorts each accepted vector with plain
// arithmetic. Two NUM=4/WIDTH=16 instances (unsigned and signed) share
// stimulus; a NUM=8/WIDTH=8 instance takes a long random run.
module tb_sort_pipe;

  localparam int S4 = 3;
  localparam int S8 = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cycleCount = 0;
  always @(posedge clock) cycleCount <= cycleCount + 1;

  int compared   = 0;
  int mismatched = 0;

  // Shared stimulus for the two NUM=4 instances
  logic        inValid  = 1'b0;
  logic        inDesc   = 1'b0;
  logic        outReady = 1'b1;
  logic [63:0] inData   = '0;

  logic        a_inReady, a_outValid, a_outDesc;
  logic [63:0] a_outData;
  logic [1:0]  a_occ;
  logic        s_inReady, s_outValid, s_outDesc;
  logic [63:0] s_outData;
  logic [1:0]  s_occ;

  // NUM=8 instance
  logic        b_inValid  = 1'b0;
  logic        b_inDesc   = 1'b0;
  logic        b_outReady = 1'b1;
  logic [63:0] b_inData   = '0;
  logic        b_inReady, b_outValid, b_outDesc;
  logic [63:0] b_outData;
  logic [2:0]  b_occ;

  sort_pipe #(.NUM(4), .WIDTH(16), .SIGNED(0)) dutA (
    .clock(clock), .reset(reset),
    .in_valid(inValid), .in_ready(a_inReady), .in_desc(inDesc), .in_data(inData),
    .out_valid(a_outValid), .out_ready(outReady), .out_desc(a_outDesc),
    .out_data(a_outData), .occupancy(a_occ)
  );

  sort_pipe #(.NUM(4), .WIDTH(16), .SIGNED(1)) dutS (
    .clock(clock), .reset(reset),
    .in_valid(inValid), .in_ready(s_inReady), .in_desc(inDesc), .in_data(inData),
    .out_valid(s_outValid), .out_ready(outReady), .out_desc(s_outDesc),
    .out_data(s_outData), .occupancy(s_occ)
  );

  sort_pipe #(.NUM(8), .WIDTH(8), .SIGNED(0)) dutB (
    .clock(clock), .reset(reset),
    .in_valid(b_inValid), .in_ready(b_inReady), .in_desc(b_inDesc), .in_data(b_inData),
    .out_valid(b_outValid), .out_ready(b_outReady), .out_desc(b_outDesc),
    .out_data(b_outData), .occupancy(b_occ)
  );

  // Directed bursts look at either the unsigned or the signed instance
  logic        useSigned = 1'b0;
  logic        selValid, selDesc;
  logic [63:0] selData;
  logic [1:0]  selOcc;
  assign selValid = useSigned ? s_outValid : a_outValid;
  assign selDesc  = useSigned ? s_outDesc  : a_outDesc;
  assign selData  = useSigned ? s_outData  : a_outData;
  assign selOcc   = useSigned ? s_occ      : a_occ;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                        input logic [15:0] l2, input logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Reference: unpack, sort numerically, repack in the requested order
  function automatic logic [63:0] refSort(input logic [63:0] v, input int num,
                                          input int width, input bit sgn, input bit desc);
    longint      keys [8];
    longint      tmp;
    logic [63:0] mask;
    logic [63:0] res;
    int          pos;
    mask = (64'd1 << width) - 64'd1;
    for (int i = 0; i < num; i++) begin
      tmp = longint'((v >> (i * width)) & mask);
      if (sgn && tmp[width-1]) tmp = tmp - (longint'(1) << width);
      keys[i] = tmp;
    end
    for (int i = 0; i < num; i++) begin
      for (int j = 0; j < num - 1 - i; j++) begin
        if (keys[j] > keys[j+1]) begin
          tmp       = keys[j];
          keys[j]   = keys[j+1];
          keys[j+1] = tmp;
        end
      end
    end
    res = '0;
    for (int i = 0; i < num; i++) begin
      pos = desc ? num - 1 - i : i;
      res = res | ((64'(keys[i]) & mask) << (pos * width));
    end
    return res;
  endfunction

  typedef struct {
    logic [63:0] data;
    logic [63:0] dataS;
    logic        desc;
    int          acceptCycle;
    bit          unstalled;
  } entry_t;

  entry_t qA[$];
  entry_t qB[$];
  entry_t eA;
  entry_t eB;
  bit     unstalledMode = 1'b0;
  int     acceptedB = 0;

  always @(posedge reset) begin
    qA.delete();
    qB.delete();
  end

  // Scoreboard for the NUM=4 pair: every transfer pops the oldest accepted
  // vector; ready and occupancy follow from the number of vectors inside.
  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("a_in_ready", 64'(a_inReady), 64'(outReady || qA.size() < S4));
      checkOutput("a_occupancy", 64'(a_occ), 64'(qA.size()));
      checkOutput("s_occupancy", 64'(s_occ), 64'(qA.size()));
      if (a_outValid && outReady) begin
        if (qA.size() == 0) begin
          checkOutput("a_spurious_out", 64'(a_outValid), 64'(0));
        end else begin
          eA = qA.pop_front();
          checkOutput("a_order_data", a_outData, eA.data);
          checkOutput("a_order_desc", 64'(a_outDesc), 64'(eA.desc));
          checkOutput("s_out_valid", 64'(s_outValid), 64'(1));
          checkOutput("s_order_data", s_outData, eA.dataS);
        end
      end
      if (inValid && a_inReady) begin
        qA.push_back('{refSort(inData, 4, 16, 1'b0, inDesc),
                       refSort(inData, 4, 16, 1'b1, inDesc),
                       inDesc, cycleCount, 1'b0});
      end
    end
  end

  // Scoreboard for the NUM=8 instance, including latency
  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("b_in_ready", 64'(b_inReady), 64'(b_outReady || qB.size() < S8));
      checkOutput("b_occupancy", 64'(b_occ), 64'(qB.size()));
      if (b_outValid && b_outReady) begin
        if (qB.size() == 0) begin
          checkOutput("b_spurious_out", 64'(b_outValid), 64'(0));
        end else begin
          eB = qB.pop_front();
          checkOutput("b_order_data", b_outData, eB.data);
          checkOutput("b_order_desc", 64'(b_outDesc), 64'(eB.desc));
          if (eB.unstalled)
            checkOutput("b_latency", 64'(cycleCount - eB.acceptCycle), 64'(S8));
          else
            checkOutput("b_latency_min", 64'((cycleCount - eB.acceptCycle) >= S8), 64'(1));
        end
      end
      if (b_inValid && b_inReady) begin
        qB.push_back('{refSort(b_inData, 8, 8, 1'b0, b_inDesc), 64'd0,
                       b_inDesc, cycleCount, unstalledMode});
        acceptedB++;
      end
    end
  end

  logic [63:0] burstIn   [4];
  logic [63:0] burstExp  [4];
  logic        burstDesc [4];

  // Feed n vectors on consecutive cycles with out_ready high and check the
  // exact cycle each one emerges.
  task automatic applyStimulus(input int n);
    int expOcc;
    int done;
    for (int t = 0; t <= n + S4; t++) begin
      if (t < n) begin
        inValid = 1'b1;
        inData  = burstIn[t];
        inDesc  = burstDesc[t];
      end else begin
        inValid = 1'b0;
      end
      @(negedge clock);
      done   = (t - S4 < 0) ? 0 : ((t - S4 < n) ? t - S4 : n);
      expOcc = ((t < n) ? t : n) - done;
      if (t < n) checkOutput("burst_in_ready", 64'(a_inReady), 64'(1));
      checkOutput("burst_occupancy", 64'(selOcc), 64'(expOcc));
      if (t >= S4 && t - S4 < n) begin
        checkOutput("burst_out_valid", 64'(selValid), 64'(1));
        checkOutput("burst_out_data", selData, burstExp[t-S4]);
        checkOutput("burst_out_desc", 64'(selDesc), 64'(burstDesc[t-S4]));
      end else begin
        checkOutput("burst_out_idle", 64'(selValid), 64'(0));
      end
      @(posedge clock);
      #1;
    end
  endtask

  logic [63:0] bpVec [5];
  int          k;
  int          guard;
  logic        accepted;

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_out_valid", 64'(a_outValid), 64'(0));
    checkOutput("rst_occupancy", 64'(a_occ), 64'(0));
    checkOutput("rst_out_data", a_outData, 64'(0));
    checkOutput("rst_out_desc", 64'(a_outDesc), 64'(0));
    checkOutput("rst_b_out_valid", 64'(b_outValid), 64'(0));
    checkOutput("rst_b_out_data", b_outData, 64'(0));
    @(negedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] basic ascending / descending / back-to-back");
    outReady  = 1'b1;
    useSigned = 1'b0;
    burstIn[0] = pack4(16'd3, 16'd1, 16'd4, 16'd2); burstDesc[0] = 1'b0;
    burstExp[0] = pack4(16'd1, 16'd2, 16'd3, 16'd4);
    applyStimulus(1);
    burstIn[0] = pack4(16'd3, 16'd1, 16'd4, 16'd2); burstDesc[0] = 1'b1;
    burstExp[0] = pack4(16'd4, 16'd3, 16'd2, 16'd1);
    burstIn[1] = pack4(16'hFFFF, 16'h0000, 16'h8000, 16'h0007); burstDesc[1] = 1'b0;
    burstExp[1] = pack4(16'h0000, 16'h0007, 16'h8000, 16'hFFFF);
    burstIn[2] = pack4(16'd5, 16'd5, 16'd5, 16'd5); burstDesc[2] = 1'b0;
    burstExp[2] = pack4(16'd5, 16'd5, 16'd5, 16'd5);
    applyStimulus(3);

    $display("[TB] signed compare");
    useSigned = 1'b1;
    burstIn[0] = pack4(16'h8000, 16'h0001, 16'hFFFF, 16'h0000); burstDesc[0] = 1'b0;
    burstExp[0] = pack4(16'h8000, 16'hFFFF, 16'h0000, 16'h0001);
    burstIn[1] = pack4(16'h8000, 16'h0001, 16'hFFFF, 16'h0000); burstDesc[1] = 1'b1;
    burstExp[1] = pack4(16'h0001, 16'h0000, 16'hFFFF, 16'h8000);
    applyStimulus(2);
    useSigned = 1'b0;

    $display("[TB] backpressure");
    bpVec[0] = pack4(16'd9, 16'd2, 16'd7, 16'd1);
    bpVec[1] = pack4(16'd100, 16'd50, 16'd75, 16'd25);
    bpVec[2] = pack4(16'd1, 16'd1, 16'd0, 16'd0);
    bpVec[3] = pack4(16'hABCD, 16'h1234, 16'hFFFF, 16'h0000);
    bpVec[4] = pack4(16'd42, 16'd41, 16'd40, 16'd39);
    outReady = 1'b0;
    k = 0;
    for (int t = 0; t < 5; t++) begin
      inValid = 1'b1;
      inData  = bpVec[k];
      inDesc  = k[0];
      @(negedge clock);
      checkOutput("bp_in_ready", 64'(a_inReady), 64'(t < 3));
      checkOutput("bp_occupancy", 64'(a_occ), 64'((t < 3) ? t : 3));
      if (t >= 3) begin
        checkOutput("bp_out_valid", 64'(a_outValid), 64'(1));
        checkOutput("bp_out_stable", a_outData, refSort(bpVec[0], 4, 16, 1'b0, 1'b0));
      end
      accepted = a_inReady;
      @(posedge clock);
      #1;
      if (accepted) k++;
    end
    outReady = 1'b1;
    inData   = bpVec[k];
    inDesc   = k[0];
    @(negedge clock);
    checkOutput("bp_swap_in_ready", 64'(a_inReady), 64'(1));
    checkOutput("bp_swap_occupancy", 64'(a_occ), 64'(3));
    @(posedge clock);
    #1;
    k++;
    outReady = 1'b0;
    inValid  = 1'b0;
    @(negedge clock);
    checkOutput("bp_after_swap_occ", 64'(a_occ), 64'(3));
    checkOutput("bp_after_swap_data", a_outData, refSort(bpVec[1], 4, 16, 1'b0, 1'b1));
    @(posedge clock);
    #1;
    outReady = 1'b1;
    inValid  = 1'b1;
    inData   = bpVec[k];
    inDesc   = k[0];
    @(posedge clock);
    #1;
    inValid = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    checkOutput("drain_occupancy", 64'(a_occ), 64'(0));
    checkOutput("drain_out_valid", 64'(a_outValid), 64'(0));
    checkOutput("drain_queue_empty", 64'(qA.size()), 64'(0));

    $display("[TB] reset mid-flight");
    outReady = 1'b0;
    inValid  = 1'b1;
    inDesc   = 1'b1;
    inData   = pack4(16'd8, 16'd6, 16'd7, 16'd5);
    @(posedge clock);
    #1;
    inData = pack4(16'd3, 16'd0, 16'd9, 16'd1);
    @(posedge clock);
    #1;
    inValid = 1'b0;
    inDesc  = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("mid_out_valid", 64'(a_outValid), 64'(1));
    checkOutput("mid_occupancy", 64'(a_occ), 64'(2));
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_out_valid", 64'(a_outValid), 64'(0));
    checkOutput("async_rst_occupancy", 64'(a_occ), 64'(0));
    checkOutput("async_rst_out_data", a_outData, 64'(0));
    checkOutput("async_rst_out_desc", 64'(a_outDesc), 64'(0));
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    outReady = 1'b1;
    burstIn[0] = pack4(16'd2, 16'd9, 16'd4, 16'd4); burstDesc[0] = 1'b0;
    burstExp[0] = pack4(16'd2, 16'd4, 16'd4, 16'd9);
    applyStimulus(1);

    $display("[TB] NUM=8 random, unstalled segment");
    unstalledMode = 1'b1;
    b_outReady    = 1'b1;
    repeat (300) begin
      b_inValid = ($urandom_range(0, 3) != 0);
      b_inData  = {$urandom, $urandom};
      b_inDesc  = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
    end
    b_inValid = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    unstalledMode = 1'b0;

    $display("[TB] NUM=8 random, with backpressure");
    guard = 0;
    while (acceptedB < 10000 && guard < 60000) begin
      b_inValid  = ($urandom_range(0, 3) != 0);
      b_inData   = {$urandom, $urandom};
      b_inDesc   = 1'($urandom_range(0, 1));
      b_outReady = ($urandom_range(0, 3) != 0);
      @(posedge clock);
      #1;
      guard++;
    end
    if (acceptedB < 10000) checkOutput("rand_accept_budget", 64'(acceptedB), 64'(10000));
    b_inValid  = 1'b0;
    b_outReady = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    checkOutput("b_drain_occupancy", 64'(b_occ), 64'(0));
    checkOutput("b_drain_queue_empty", 64'(qB.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
